// File: rtl/program_loader.sv
// program_loader: writer side of the CPU instruction memory.
// Takes a framed stream (LEN, LEN payload words, CHECKSUM) over valid/ready,
// writes payload word k to address k one cycle after acceptance, and keeps
// the CPU in reset until a frame closes with a matching checksum.
module program_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Width wide enough to compare a LEN word against DEPTH without truncation.
  localparam int LW = (DATA_WIDTH > ADDR_WIDTH + 1) ? DATA_WIDTH : ADDR_WIDTH + 1;
  localparam logic [LW-1:0]         DEPTH_L = LW'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH:0]   cnt_r;
  logic [ADDR_WIDTH:0]   len_r;
  logic [DATA_WIDTH-1:0] csum_r;

  logic [LW-1:0]         len_word_s;
  logic                  len_ok_s;
  logic [ADDR_WIDTH:0]   cnt_next_s;
  logic                  accept_s;

  // Running checksum: modular sum of payload words.
  function automatic logic [DATA_WIDTH-1:0] csum_add(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] word
  );
    return acc + word;
  endfunction

  assign len_word_s = LW'(in_data);
  assign len_ok_s   = (len_word_s != {LW{1'b0}}) && (len_word_s <= DEPTH_L);
  assign cnt_next_s = cnt_r + CNT_ONE;
  assign accept_s   = in_valid && in_ready;

  // Ready is combinational so a word can be taken in the same cycle the state allows it.
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      ST_LEN, ST_DATA, ST_CSUM: in_ready = 1'b1;
      default:                  in_ready = 1'b0;
    endcase
  end

  // Frame FSM with registered status, memory write port and CPU reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {(ADDR_WIDTH+1){1'b0}};
      len_r    <= {(ADDR_WIDTH+1){1'b0}};
      csum_r   <= {DATA_WIDTH{1'b0}};
      mem_wr   <= 1'b0;
      mem_addr <= {ADDR_WIDTH{1'b0}};
      mem_data <= {DATA_WIDTH{1'b0}};
      cpu_rst  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_r <= ST_LEN;
            cnt_r   <= {(ADDR_WIDTH+1){1'b0}};
            csum_r  <= {DATA_WIDTH{1'b0}};
            cpu_rst <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
          end
        end
        ST_LEN: begin
          if (accept_s) begin
            if (len_ok_s) begin
              len_r   <= len_word_s[ADDR_WIDTH:0];
              state_r <= ST_DATA;
            end else begin
              state_r <= ST_ERR;
              busy    <= 1'b0;
              err     <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            mem_wr   <= 1'b1;
            mem_addr <= cnt_r[ADDR_WIDTH-1:0];
            mem_data <= in_data;
            cnt_r    <= cnt_next_s;
            csum_r   <= csum_add(csum_r, in_data);
            if (cnt_next_s == len_r) begin
              state_r <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (accept_s) begin
            busy <= 1'b0;
            if (in_data == csum_r) begin
              state_r <= ST_DONE;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= ST_ERR;
              err     <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cpu_rst <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: framing, checksum, length limits,
// back-pressure, mid-frame reset and start handling.
module tb_program_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic       err;

  int total;
  int bad;

  // Write log filled by the monitor; tests compare against it relative to a base index.
  int         wr_n;
  logic [4:0] log_addr [0:255];
  logic [7:0] log_data [0:255];

  program_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write strobe, sampled mid-cycle.
  initial wr_n = 0;
  always @(negedge clk) begin
    if (mem_wr && !rst && wr_n < 256) begin
      log_addr[wr_n] = mem_addr;
      log_data[wr_n] = mem_data;
      wr_n = wr_n + 1;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_timeout word=%h in_ready=%b want 1", w, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({cpu_rst, mem_wr, mem_addr, mem_data, in_ready, busy, done, err} !==
        {1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got cpu_rst=%b wr=%b addr=%h data=%h rdy=%b busy=%b done=%b err=%b",
               cpu_rst, mem_wr, mem_addr, mem_data, in_ready, busy, done, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    int base;
    base = wr_n;
    pulse_start();
    total++;
    if ({busy, in_ready, cpu_rst} !== 3'b111) begin
      bad++; $display("FAIL len_entry busy/rdy/cpu_rst=%b want 111", {busy, in_ready, cpu_rst});
    end
    send(8'd3); send(8'h11); send(8'h22); send(8'h33); send(8'h66);
    total++;
    if (wr_n - base !== 3) begin
      bad++; $display("FAIL good_wr_count got %0d want 3", wr_n - base);
    end else begin
      total++;
      if ({log_addr[base], log_addr[base+1], log_addr[base+2]} !== {5'd0, 5'd1, 5'd2} ||
          {log_data[base], log_data[base+1], log_data[base+2]} !== {8'h11, 8'h22, 8'h33}) begin
        bad++;
        $display("FAIL good_writes got %h/%h %h/%h %h/%h want 00/11 01/22 02/33",
                 log_addr[base], log_data[base], log_addr[base+1], log_data[base+1],
                 log_addr[base+2], log_data[base+2]);
      end
    end
    total++;
    if ({done, err, cpu_rst, busy} !== 4'b1000) begin
      bad++; $display("FAIL good_status done/err/cpu_rst/busy=%b want 1000", {done, err, cpu_rst, busy});
    end
  endtask

  task automatic test_bad_csum();
    int base;
    base = wr_n;
    pulse_start();
    send(8'd3); send(8'h11); send(8'h22); send(8'h33); send(8'h67);
    total++;
    if (wr_n - base !== 3) begin
      bad++; $display("FAIL badcs_wr_count got %0d want 3", wr_n - base);
    end
    total++;
    if ({done, err, cpu_rst, busy} !== 4'b0110) begin
      bad++; $display("FAIL badcs_status done/err/cpu_rst/busy=%b want 0110", {done, err, cpu_rst, busy});
    end
  endtask

  task automatic test_bad_len(input logic [7:0] n);
    int base;
    base = wr_n;
    pulse_start();
    send(n);
    total++;
    if ({err, done, busy, in_ready, cpu_rst} !== 5'b10001) begin
      bad++;
      $display("FAIL badlen_%0d err/done/busy/rdy/cpu_rst=%b want 10001", n, {err, done, busy, in_ready, cpu_rst});
    end
    repeat (3) @(negedge clk);
    total++;
    if (wr_n - base !== 0) begin
      bad++; $display("FAIL badlen_%0d_writes got %0d want 0", n, wr_n - base);
    end
  endtask

  task automatic test_full_depth();
    int base;
    int errs;
    base = wr_n;
    errs = 0;
    pulse_start();
    send(8'd32);
    for (int i = 0; i < 32; i++) send(8'hFF);
    send(8'hE0);
    total++;
    if (wr_n - base !== 32) begin
      bad++; $display("FAIL full_wr_count got %0d want 32", wr_n - base);
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (log_addr[base+i] !== 5'(i) || log_data[base+i] !== 8'hFF) errs++;
      end
      total++;
      if (errs !== 0) begin
        bad++; $display("FAIL full_writes %0d entries wrong want 0", errs);
      end
    end
    total++;
    if ({done, err, cpu_rst} !== 3'b100) begin
      bad++; $display("FAIL full_status done/err/cpu_rst=%b want 100", {done, err, cpu_rst});
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [0:5];
    int base;
    int idx;
    int c;
    logic acc;
    words[0] = 8'd4; words[1] = 8'h01; words[2] = 8'h02;
    words[3] = 8'h03; words[4] = 8'h04; words[5] = 8'h0A;
    base = wr_n;
    pulse_start();
    idx = 0;
    c = 0;
    while (idx < 6 && c < 100) begin
      @(negedge clk);
      in_valid = (c % 3 == 0);
      in_data  = words[idx];
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      c++;
    end
    #1;
    in_valid = 1'b0;
    total++;
    if (idx !== 6) begin
      bad++; $display("FAIL bp_timeout accepted %0d want 6", idx);
    end
    @(negedge clk);
    total++;
    if (wr_n - base !== 4) begin
      bad++; $display("FAIL bp_wr_count got %0d want 4", wr_n - base);
    end else begin
      total++;
      if ({log_addr[base], log_addr[base+1], log_addr[base+2], log_addr[base+3]} !==
          {5'd0, 5'd1, 5'd2, 5'd3} ||
          {log_data[base], log_data[base+1], log_data[base+2], log_data[base+3]} !==
          {8'h01, 8'h02, 8'h03, 8'h04}) begin
        bad++; $display("FAIL bp_writes addresses or data not contiguous 0..3 / 01..04");
      end
    end
    total++;
    if ({done, err, cpu_rst} !== 3'b100) begin
      bad++; $display("FAIL bp_status done/err/cpu_rst=%b want 100", {done, err, cpu_rst});
    end
  endtask

  task automatic test_mid_reset();
    pulse_start();
    send(8'd5); send(8'h0A); send(8'h0B);
    total++;
    if ({mem_wr, mem_addr, mem_data} !== {1'b1, 5'd1, 8'h0B}) begin
      bad++; $display("FAIL midrst_pre wr/addr/data=%b/%h/%h want 1/01/0b", mem_wr, mem_addr, mem_data);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({cpu_rst, mem_wr, mem_addr, mem_data, in_ready, busy, done, err} !==
        {1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_state got cpu_rst=%b wr=%b addr=%h data=%h rdy=%b busy=%b done=%b err=%b",
               cpu_rst, mem_wr, mem_addr, mem_data, in_ready, busy, done, err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_start_handling();
    int base;
    base = wr_n;
    pulse_start();
    send(8'd2); send(8'h05);
    pulse_start();
    total++;
    if ({busy, in_ready} !== 2'b11) begin
      bad++; $display("FAIL start_in_data busy/rdy=%b want 11", {busy, in_ready});
    end
    send(8'h06); send(8'h0B);
    total++;
    if (wr_n - base !== 2 || done !== 1'b1) begin
      bad++; $display("FAIL start_ignored writes=%0d done=%b want 2/1", wr_n - base, done);
    end else begin
      total++;
      if ({log_addr[base], log_data[base], log_addr[base+1], log_data[base+1]} !==
          {5'd0, 8'h05, 5'd1, 8'h06}) begin
        bad++; $display("FAIL start_ignored_writes got %h/%h %h/%h want 00/05 01/06",
                        log_addr[base], log_data[base], log_addr[base+1], log_data[base+1]);
      end
    end
    pulse_start();
    total++;
    if ({cpu_rst, busy, in_ready, done} !== 4'b1110) begin
      bad++; $display("FAIL reload cpu_rst/busy/rdy/done=%b want 1110", {cpu_rst, busy, in_ready, done});
    end
    send(8'd1); send(8'h07); send(8'h07);
    total++;
    if ({done, cpu_rst} !== 2'b10) begin
      bad++; $display("FAIL reload_done done/cpu_rst=%b want 10", {done, cpu_rst});
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len(8'd0);
    test_bad_len(8'd33);
    test_full_depth();
    test_backpressure();
    test_mid_reset();
    test_start_handling();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
